// File: rtl/nibble_word_packer_if.sv
// Handshake bundle between the nibble mux, the nibble_word_packer and the word write stage.
// The master modport is the packer's view; slave is the surrounding datapath's view.
interface nibble_word_packer_if #(
  parameter int unsigned NIBBLES = 8,
  parameter int unsigned CW      = 4
);
  logic [3:0]           nib_i;
  logic                 nib_valid_i;
  logic                 nib_ready_o;
  logic                 sel_o;
  logic                 flush_i;
  logic [4*NIBBLES-1:0] word_o;
  logic [CW-1:0]        out_count_o;
  logic                 word_valid_o;
  logic                 word_ready_i;

  modport master (
    input  nib_i, nib_valid_i, flush_i, word_ready_i,
    output nib_ready_o, sel_o, word_o, out_count_o, word_valid_o
  );

  modport slave (
    output nib_i, nib_valid_i, flush_i, word_ready_i,
    input  nib_ready_o, sel_o, word_o, out_count_o, word_valid_o
  );
endinterface

// File: rtl/nibble_word_packer.sv
// Packs an alternating A/B nibble stream into NIBBLES-nibble words, with flush of partial words
// and a single output register that can be reloaded in the same cycle it is drained.
module nibble_word_packer #(
  parameter int unsigned NIBBLES = 8,
  parameter int unsigned CW      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_word_packer_if.master bus
);
  localparam int unsigned     WW      = 4 * NIBBLES;
  localparam logic [CW-1:0]   LastIdx = CW'(NIBBLES - 1);

  logic [WW-1:0] acc_q, acc_d, acc_merged;
  logic [WW-1:0] word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          word_valid_q, word_valid_d;
  logic          nib_ready, acc_fire, out_fire, flush_go, load;

  always_comb begin
    nib_ready = ~word_valid_q | bus.word_ready_i;
    acc_fire  = bus.nib_valid_i & nib_ready;
    out_fire  = word_valid_q & bus.word_ready_i;
    // A flush only emits when something is held or arriving; an empty flush is dropped.
    flush_go  = bus.flush_i & nib_ready & ((cnt_q != '0) | acc_fire);
    load      = (acc_fire & (cnt_q == LastIdx)) | flush_go;

    acc_merged = acc_q;
    if (acc_fire) begin
      acc_merged[4*cnt_q +: 4] = bus.nib_i;
    end

    acc_d        = acc_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    out_count_d  = out_count_q;
    word_valid_d = word_valid_q;

    if (out_fire) begin
      word_valid_d = 1'b0;
    end

    if (load) begin
      word_d       = acc_merged;
      out_count_d  = cnt_q + {{(CW-1){1'b0}}, acc_fire};
      word_valid_d = 1'b1;
      acc_d        = '0;
      cnt_d        = '0;
    end else if (acc_fire) begin
      acc_d = acc_merged;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      out_count_q  <= '0;
      word_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      out_count_q  <= out_count_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign bus.nib_ready_o  = nib_ready;
  assign bus.sel_o        = cnt_q[0];
  assign bus.word_o       = word_q;
  assign bus.out_count_o  = out_count_q;
  assign bus.word_valid_o = word_valid_q;
endmodule

// File: doc/nibble_word_packer.md
Name: nibble_word_packer

Overview:
- Downstream consumer of the 4-bit two-channel nibble mux in the image-filter datapath.
- Accepts the selected nibble stream under a valid/ready handshake and packs NIBBLES nibbles into one word.
- Presents each packed word to the pixel/memory write stage under a valid/ready handshake.
- Drives the mux select line so consecutive nibbles alternate between channel A and channel B.

Parameters:
- NIBBLES, 8, nibbles per output word (2..16); output width is 4*NIBBLES.
- CW, 4, width of the nibble counter and out_count; must satisfy 2^CW > NIBBLES.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- nib_i  input  4  nibble from the mux output Y.
- nib_valid_i  input  1  nib_i is valid this cycle.
- nib_ready_o  output  1  packer accepts nib_i this cycle.
- sel_o  output  1  mux select S; 0 selects channel A, 1 selects channel B.
- flush_i  input  1  emit the partial word now (one-cycle pulse).
- word_o  output  4*NIBBLES  packed word; nibble k sits in bits [4k+3:4k].
- out_count_o  output  CW  number of valid nibbles in word_o (1..NIBBLES).
- word_valid_o  output  1  word_o is valid.
- word_ready_i  input  1  downstream takes word_o this cycle.

Behaviour:
- Reset (asynchronous, immediate): accumulator=0, cnt=0, word_o=0, out_count_o=0, word_valid_o=0, sel_o=0.
- Reset mid-word discards all partial and pending data with no output.
- Accept condition: acc_fire = nib_valid_i & nib_ready_o. Output transfer: out_fire = word_valid_o & word_ready_i.
- nib_ready_o = ~word_valid_o | word_ready_i.
  - Combinational; no combinational path from nib_valid_i.
  - The packer stalls only while a completed word is held and not taken.
- sel_o = cnt[0], registered state and combinational decode only.
  - Word nibbles alternate A,B,A,B… starting with A at nibble 0.
  - sel_o returns to 0 at every word start, including after a flush.
- On acc_fire with cnt < NIBBLES-1:
  - accumulator nibble[cnt] <= nib_i.
  - cnt <= cnt+1.
- On acc_fire with cnt == NIBBLES-1 (word complete):
  - word_o <= accumulator with nibble[NIBBLES-1]=nib_i.
  - out_count_o <= NIBBLES.
  - word_valid_o <= 1.
  - cnt <= 0, accumulator <= 0.
  - Latency: the last nibble accepted at edge N gives word_valid_o=1 after edge N.
- Flush (flush_i=1 with cnt>0 and nib_ready_o=1):
  - word_o <= accumulator, including nib_i if acc_fire occurs in the same cycle.
  - out_count_o <= cnt + acc_fire.
  - word_valid_o <= 1; cnt <= 0, accumulator <= 0.
  - Unused upper nibbles are 0.
- Flush boundary conditions:
  - Flush with cnt=0 and no acc_fire: ignored.
  - Flush with cnt=0 and acc_fire: emits a 1-nibble word.
  - Flush while nib_ready_o=0: ignored; the requester must hold it.
  - Flush coinciding with word completion: identical to a normal completion.
- Output register:
  - When out_fire occurs without a new word being loaded, word_valid_o <= 0.
  - When out_fire and a new completion/flush occur in the same cycle, word_valid_o stays 1 and word_o/out_count_o take the new word. Throughput is one word per NIBBLES cycles with no bubbles.
  - While word_valid_o=1 and word_ready_i=0, word_o and out_count_o are held stable.
- Back-pressure:
  - nib_valid_i with nib_ready_o=0 is not consumed.
  - cnt and sel_o hold; the upstream stage keeps nib_i stable.
- Counter wrap: cnt never exceeds NIBBLES-1; there is no modulo-2^CW wrap.

Test Plan:
- Reset pulse mid-word after 3 nibbles -> all outputs 0 immediately; the next 8 nibbles 1..8 yield word_o=32'h87654321, count 8.
- Continuous stream 0x1..0xF,0x0,… with word_ready_i=1 -> a word every 8 cycles, first 32'h87654321, sel_o pattern 0,1,0,1… per nibble, no gaps.
- Hold word_ready_i=0 after the first word -> nib_ready_o=0 and the word stays stable; release -> the next nibble is accepted in the same cycle as out_fire.
- 3 nibbles A,B,C then flush_i with no valid -> word_o=32'h00000CBA, out_count_o=3; next word starts with sel_o=0.
- flush_i together with the 5th accepted nibble 5 (prior 1..4) -> word_o=32'h00054321, count 5.
- flush_i with empty accumulator -> no word_valid_o; flush_i while stalled -> ignored, no data loss.
